fifo_axis_reader: RTL and testbench
===================================

# fifo_axis_reader

Read-side adapter that drains a first-word-fall-through FIFO (`if_empty_n`/`if_read`/`if_dout` handshake) and presents the data as an AXI4-Stream master with a registered 2-entry output buffer. It sits at the consumer end of an inter-task FIFO channel, where a FIFO stream leaves toward an AXIS sink. It frames the stream into fixed-length packets by generating `m_axis_tlast`. `m_axis_tready` has no combinational path to `if_read`, which keeps the boundary timing-clean.

## Interface
- `DATA_WIDTH`, 32, width of FIFO data and `m_axis_tdata`
- `PKT_LEN`, 16, beats per packet; `tlast` is set on every `PKT_LEN`-th beat; legal range is 1 or more
- `clk`  in  1  clock; all logic is on the rising edge
- `reset_n`  in  1  reset, asynchronous and active-low
- `if_empty_n`  in  1  FIFO has a word; `if_dout` is valid (FWFT)
- `if_dout`  in  DATA_WIDTH  FIFO head word
- `if_read`  out  1  pop the FIFO this cycle
- `if_read_ce`  out  1  constant 1
- `m_axis_tvalid`  out  1  stream beat valid
- `m_axis_tready`  in  1  sink accepts beat
- `m_axis_tdata`  out  DATA_WIDTH  beat data
- `m_axis_tlast`  out  1  last beat of packet

## Operation
- **Buffer.** The buffer holds two entries, head and skid, each storing {data, last}. Occupancy `occ` takes values 0, 1 or 2.
- **Stream outputs.** `m_axis_tvalid = (occ != 0)`. `tdata` and `tlast` always come from the head entry.
- **Pop.** `if_read = if_empty_n & (occ != 2) & reset_n`. It depends only on registered state and `if_empty_n`, never on `m_axis_tready`.
- **Push.** A push happens when `if_read` is 1: `{if_dout, last_flag}` enters the buffer.
- **Drain.** A drain happens when `m_axis_tvalid & m_axis_tready`.
- **Occupancy transitions:**
  - push only: `occ + 1`. The new entry goes to the head if `occ` was 0, otherwise to skid.
  - drain only: `occ - 1`. If `occ` was 2, skid moves to head.
  - push and drain together: `occ` is unchanged. If `occ` was 1, the new entry goes to the head.
  - A push at `occ == 2` cannot occur.
- **Beat counter.** `bcnt` is `max(1, $clog2(PKT_LEN))` bits wide and advances on push, not on drain.
  - `last_flag = (bcnt == PKT_LEN-1)`.
  - On push, `bcnt` wraps to 0 when `last_flag` is set, otherwise it increments.
  - With `PKT_LEN == 1`, every beat has `tlast = 1`.
- **Stability.** While `tvalid` is high and `tready` is low, the head entry (`tdata`/`tlast`) holds stable.
- **Reset values:** `occ = 0`, `bcnt = 0`, `m_axis_tvalid = 0`, `m_axis_tdata = 0`, `m_axis_tlast = 0`, `if_read = 0`.
- **Reset mid-operation.** Buffered beats are discarded, any partial packet count is cleared, and the next beat after release starts a new packet.

## Timing
- FIFO pop to `m_axis_tvalid`: 1 cycle. Data popped at edge N is visible on the stream after edge N.
- Sustained throughput is 1 beat/cycle when the FIFO stays non-empty and `tready` stays high; steady state is `occ == 1`.
- After `tready` deasserts, at most 1 more word is popped (fills skid). `if_read` drops once `occ == 2`.
- After `tready` reasserts with `occ == 2`: drain that cycle, and `if_read` is high again the cycle after.
- Empty FIFO: `if_read` stays 0. `tvalid` falls after the last buffered beat drains.

## Configuration
- Macro `FIFO_AXIS_READER_STATS_EN`.
- **Defined:** adds two output ports.
  - `stat_beats` out 32: count of stream handshakes.
  - `stat_pkts` out 32: count of handshakes with `tlast = 1`.
  - Both reset to 0 and wrap at 2^32.
- **Undefined:** these ports and counters do not exist. Functional behaviour is otherwise identical.

## Test plan
- **Reset behaviour:** hold `reset_n = 0` with `if_empty_n = 1` → `if_read = 0` and `tvalid = 0`. After release, `if_read = 1` on the first cycle and `tvalid = 1` one cycle later.
- **Streaming, PKT_LEN=4:** FIFO supplies 0..11 with `tready = 1` → 12 consecutive beats at 1/cycle, `tlast` on data 3, 7 and 11.
- **Backpressure:** `tready = 0` for 5 cycles mid-stream → exactly 2 words buffered, `if_read = 0` after that, `tdata` stable. On release, no words are lost or duplicated.
- **Bubbles:** `if_empty_n` toggled randomly with random `tready` over 1000 beats → output sequence equals input sequence, and `tlast` exactly every `PKT_LEN` beats.
- **Reset mid-packet:** reset after 2 of 4 beats with `occ = 2` → buffer empties. The next 4 beats form a full packet with `tlast` on the 4th.
- **Statistics:** with `FIFO_AXIS_READER_STATS_EN` and `PKT_LEN = 1`, send 10 beats → `stat_beats = 10`, `stat_pkts = 10`.

Source files
------------

// File: rtl/fifo_axis_reader_if.sv
// Groups the FIFO read-side and AXI4-Stream master signals of fifo_axis_reader.
// master: the adapter's view (pops the FIFO, drives the stream).
// slave: the environment's view (FIFO head plus stream sink).
`timescale 1ns/1ps
interface fifo_axis_reader_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  if_empty_n;
    logic [DATA_WIDTH-1:0] if_dout;
    logic                  if_read;
    logic                  if_read_ce;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;
    logic [DATA_WIDTH-1:0] m_axis_tdata;
    logic                  m_axis_tlast;

    modport master (
        input  if_empty_n,
        input  if_dout,
        output if_read,
        output if_read_ce,
        output m_axis_tvalid,
        input  m_axis_tready,
        output m_axis_tdata,
        output m_axis_tlast
    );

    modport slave (
        output if_empty_n,
        output if_dout,
        input  if_read,
        input  if_read_ce,
        input  m_axis_tvalid,
        output m_axis_tready,
        input  m_axis_tdata,
        input  m_axis_tlast
    );
endinterface

// File: rtl/fifo_axis_reader.sv
// Purpose: drains an FWFT FIFO into an AXI4-Stream master, framing fixed PKT_LEN packets via tlast.
// Latency: 1 cycle from FIFO pop to tvalid; 1 beat/cycle sustained with occupancy 1.
// Backpressure: 2-entry head/skid buffer, so tready never reaches if_read combinationally.
// Optional macro FIFO_AXIS_READER_STATS_EN adds stat_beats/stat_pkts handshake counters.
`timescale 1ns/1ps
module fifo_axis_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int PKT_LEN    = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    fifo_axis_reader_if.master  bus
`ifdef FIFO_AXIS_READER_STATS_EN
    ,
    output logic [31:0]         stat_beats,
    output logic [31:0]         stat_pkts
`endif
);

    // A single-beat packet still needs a 1-bit counter that never leaves 0.
    localparam int BCNT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(PKT_LEN - 1);

    // Buffer occupancy encodings.
    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

    logic [1:0]            occ_q, occ_d;
    logic [DATA_WIDTH-1:0] head_dat_q, head_dat_d;
    logic                  head_last_q, head_last_d;
    logic [DATA_WIDTH-1:0] skid_dat_q, skid_dat_d;
    logic                  skid_last_q, skid_last_d;
    logic [BCNT_W-1:0]     bcnt_q, bcnt_d;

    logic push;
    logic drain;
    logic tvalid;
    logic last_flag;

    // The pop decision uses only registered occupancy and FIFO status; reset gates it off.
    assign push      = bus.if_empty_n & (occ_q != OCC_FULL) & reset_n;
    assign tvalid    = (occ_q != OCC_EMPTY);
    assign drain     = tvalid & bus.m_axis_tready;
    assign last_flag = (bcnt_q == BCNT_LAST);

    assign bus.if_read       = push;
    assign bus.if_read_ce    = 1'b1;
    assign bus.m_axis_tvalid = tvalid;
    assign bus.m_axis_tdata  = head_dat_q;
    assign bus.m_axis_tlast  = head_last_q;

    // Next-state for buffer entries, occupancy and the packet beat counter.
    always_comb begin
        occ_d       = occ_q;
        head_dat_d  = head_dat_q;
        head_last_d = head_last_q;
        skid_dat_d  = skid_dat_q;
        skid_last_d = skid_last_q;
        bcnt_d      = bcnt_q;

        // Packet framing follows the FIFO side, so stalls on the stream never shift tlast.
        if (push) begin
            bcnt_d = last_flag ? '0 : bcnt_q + 1'b1;
        end

        case ({push, drain})
            2'b10: begin
                occ_d = occ_q + 2'd1;
                if (occ_q == OCC_EMPTY) begin
                    head_dat_d  = bus.if_dout;
                    head_last_d = last_flag;
                end else begin
                    skid_dat_d  = bus.if_dout;
                    skid_last_d = last_flag;
                end
            end
            2'b01: begin
                occ_d = occ_q - 2'd1;
                if (occ_q == OCC_FULL) begin
                    head_dat_d  = skid_dat_q;
                    head_last_d = skid_last_q;
                end
            end
            2'b11: begin
                // Push never happens when full, so the only case here is replacing the head.
                if (occ_q == OCC_ONE) begin
                    head_dat_d  = bus.if_dout;
                    head_last_d = last_flag;
                end
            end
            default: begin
            end
        endcase
    end

    // Buffer and counter state; reset discards buffered beats and restarts the packet.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            occ_q       <= OCC_EMPTY;
            head_dat_q  <= '0;
            head_last_q <= 1'b0;
            skid_dat_q  <= '0;
            skid_last_q <= 1'b0;
            bcnt_q      <= '0;
        end else begin
            occ_q       <= occ_d;
            head_dat_q  <= head_dat_d;
            head_last_q <= head_last_d;
            skid_dat_q  <= skid_dat_d;
            skid_last_q <= skid_last_d;
            bcnt_q      <= bcnt_d;
        end
    end

`ifdef FIFO_AXIS_READER_STATS_EN
    logic [31:0] stat_beats_q, stat_beats_d;
    logic [31:0] stat_pkts_q, stat_pkts_d;

    // Handshake counters, free-running modulo 2^32.
    always_comb begin
        stat_beats_d = stat_beats_q;
        stat_pkts_d  = stat_pkts_q;
        if (drain) begin
            stat_beats_d = stat_beats_q + 32'd1;
            if (head_last_q) begin
                stat_pkts_d = stat_pkts_q + 32'd1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_beats_q <= '0;
            stat_pkts_q  <= '0;
        end else begin
            stat_beats_q <= stat_beats_d;
            stat_pkts_q  <= stat_pkts_d;
        end
    end

    assign stat_beats = stat_beats_q;
    assign stat_pkts  = stat_pkts_q;
`endif

endmodule

// File: tb/tb_fifo_axis_reader.sv
// Scoreboard bench for fifo_axis_reader: PKT_LEN=4 instance plus a PKT_LEN=1 twin on the same inputs.
// Popped words are queued with their expected tlast; a monitor pops and compares on each handshake.
// Covers reset, streaming, backpressure, random bubbles and reset mid-packet.
`timescale 1ns/1ps
module tb_fifo_axis_reader;

    localparam int DW  = 32;
    localparam int PKT = 4;

    typedef struct packed {
        logic          last;
        logic [DW-1:0] dat;
    } beat_t;

    logic clk;
    logic reset_n;

    fifo_axis_reader_if #(.DATA_WIDTH(DW)) if0 ();
    fifo_axis_reader_if #(.DATA_WIDTH(DW)) if1 ();

    assign if1.if_empty_n    = if0.if_empty_n;
    assign if1.if_dout       = if0.if_dout;
    assign if1.m_axis_tready = if0.m_axis_tready;

`ifdef FIFO_AXIS_READER_STATS_EN
    logic [31:0] sb0, sp0, sb1, sp1;
`endif

    fifo_axis_reader #(.DATA_WIDTH(DW), .PKT_LEN(PKT)) u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (if0.master)
`ifdef FIFO_AXIS_READER_STATS_EN
        ,
        .stat_beats (sb0),
        .stat_pkts  (sp0)
`endif
    );

    fifo_axis_reader #(.DATA_WIDTH(DW), .PKT_LEN(1)) u_dut1 (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (if1.master)
`ifdef FIFO_AXIS_READER_STATS_EN
        ,
        .stat_beats (sb1),
        .stat_pkts  (sp1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pushed = 0;
    int hs_cnt = 0;
    int pkt_cnt = 0;
    logic [DW-1:0] src_q[$];
    beat_t         exp_q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    // One clock cycle: drive at negedge, check control outputs against the model occupancy, record pops.
    task automatic step(input logic rst, input logic en, input logic rdy);
        int occ;
        @(negedge clk);
        if (!rst) begin
            reset_n = 1'b0;
            exp_q.delete();
            pushed  = 0;
            hs_cnt  = 0;
            pkt_cnt = 0;
        end else begin
            reset_n = 1'b1;
        end
        if0.if_empty_n    = en && (src_q.size() != 0);
        if0.if_dout       = (src_q.size() != 0) ? src_q[0] : '0;
        if0.m_axis_tready = rdy;
        #1;
        occ = exp_q.size();
        chk("tvalid", {63'd0, if0.m_axis_tvalid}, {63'd0, reset_n && occ != 0});
        chk("tvalid_p1", {63'd0, if1.m_axis_tvalid}, {63'd0, reset_n && occ != 0});
        chk("if_read", {63'd0, if0.if_read}, {63'd0, reset_n && if0.if_empty_n && occ != 2});
        if (!reset_n) begin
            chk("rst_tdata", {32'd0, if0.m_axis_tdata}, 64'd0);
            chk("rst_tlast", {63'd0, if0.m_axis_tlast}, 64'd0);
        end
        if (if0.if_read) begin
            exp_q.push_back({((pushed % PKT) == PKT - 1), if0.if_dout});
            pushed++;
            void'(src_q.pop_front());
        end
    endtask

    // Monitor: compare every handshake against the scoreboard and check hold-under-stall.
    initial begin
        logic          prev_stall;
        logic [DW-1:0] prev_dat;
        logic          prev_last;
        beat_t         e;
        prev_stall = 1'b0;
        prev_dat   = '0;
        prev_last  = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (!reset_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("hold_tdata", {32'd0, if0.m_axis_tdata}, {32'd0, prev_dat});
                    chk("hold_tlast", {63'd0, if0.m_axis_tlast}, {63'd0, prev_last});
                end
                if (if0.m_axis_tvalid && if0.m_axis_tready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("tdata", {32'd0, if0.m_axis_tdata}, {32'd0, e.dat});
                        chk("tlast", {63'd0, if0.m_axis_tlast}, {63'd0, e.last});
                        chk("tdata_p1", {32'd0, if1.m_axis_tdata}, {32'd0, e.dat});
                        chk("tlast_p1", {63'd0, if1.m_axis_tlast}, 64'd1);
                        hs_cnt++;
                        if (e.last) pkt_cnt++;
                    end
                end
                prev_stall = if0.m_axis_tvalid && !if0.m_axis_tready;
                prev_dat   = if0.m_axis_tdata;
                prev_last  = if0.m_axis_tlast;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int start_hs;
        reset_n           = 1'b0;
        if0.if_empty_n    = 1'b0;
        if0.if_dout       = '0;
        if0.m_axis_tready = 1'b0;

        // Reset with data waiting: no pops, no valid.
        for (int i = 0; i < 12; i++) src_q.push_back(i);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1);
        chk("read_ce", {63'd0, if0.if_read_ce}, 64'd1);

        // Streaming 0..11 at full rate; tlast on 3, 7, 11 via the model.
        start_hs = hs_cnt;
        for (int i = 0; i < 13; i++) step(1'b1, 1'b1, 1'b1);
        #2;
        chk("stream_rate", hs_cnt - start_hs, 64'd12);

        // Backpressure mid-stream: skid fills, pops stop, head holds.
        for (int i = 0; i < 10; i++) src_q.push_back($urandom);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
        chk("bp_buffered", exp_q.size(), 64'd2);
        for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b1);

        // Random bubbles on both sides for 1000 beats.
        start_hs = hs_cnt;
        for (int i = 0; i < 20000 && (hs_cnt - start_hs) < 1000; i++) begin
            while (src_q.size() < 4) src_q.push_back($urandom);
            step(1'b1, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
        end
        chk("bubble_beats", {63'd0, (hs_cnt - start_hs) >= 1000}, 64'd1);
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) step(1'b1, 1'b0, 1'b1);

        // Reset mid-packet with two beats delivered and two buffered.
        src_q.delete();
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) src_q.push_back(32'hA000_0000 + i);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 1'b0);
        chk("mid_buffered", exp_q.size(), 64'd2);
        chk("mid_delivered", hs_cnt, 64'd2);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        start_hs = hs_cnt;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) step(1'b1, 1'b0, 1'b1);
        #2;
        chk("post_rst_beats", hs_cnt - start_hs, 64'd4);
        chk("post_rst_pkts", pkt_cnt, 64'd1);
        chk("drained", exp_q.size(), 64'd0);

`ifdef FIFO_AXIS_READER_STATS_EN
        chk("stat_beats", {32'd0, sb0}, hs_cnt);
        chk("stat_pkts", {32'd0, sp0}, pkt_cnt);
        chk("stat_beats_p1", {32'd0, sb1}, hs_cnt);
        chk("stat_pkts_p1", {32'd0, sp1}, hs_cnt);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
